// File: rtl/fp16_fpu.sv
// fp16_fpu: registered binary16 add/sub/mul/max with one-cycle latency.
// Subnormal inputs read as signed zero and tiny results flush to signed zero.
// Rounding is round-to-nearest-even.
module fp16_fpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic [1:0]  op,
  output logic [15:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;
  localparam logic [1:0]  OP_MAX = 2'b11;
  localparam logic [15:0] QNAN   = 16'h7E00;
  localparam logic [14:0] INF    = 15'h7C00;

  // Round a normalised significand and pack it.
  // sig[13] is the hidden one, sig[12:3] is the fraction, and sig[2:0] are guard, round and sticky.
  // Returns {result, overflow, underflow, inexact}.
  function automatic logic [18:0] round_pack(input logic sgn,
                                             input logic signed [7:0] e,
                                             input logic [13:0] sig);
    logic               up;
    logic [11:0]        rnd;
    logic signed [7:0]  e_r;
    logic [9:0]         man;
    logic               inx;
    inx = |sig[2:0];
    up  = sig[2] & (sig[1] | sig[0] | sig[3]);
    rnd = {1'b0, sig[13:3]} + {11'b0, up};
    e_r = rnd[11] ? e + 8'sd1 : e;
    man = rnd[11] ? rnd[10:1] : rnd[9:0];
    if (e_r >= 8'sd31)
      return {sgn, INF, 1'b1, 1'b0, 1'b1};
    else if (e_r <= 8'sd0)
      return {sgn, 15'h0000, 1'b0, 1'b1, 1'b1};
    else
      return {sgn, e_r[4:0], man, 1'b0, 1'b0, inx};
  endfunction

  // Count leading zeros of a 14-bit value; a zero input is handled by the caller.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    logic       found;
    n = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  // ---- stage p0: operand decode and combinational datapath ----
  logic        a_sgn_p0, b_sgn_p0, b_sgn_eff_p0;
  logic [4:0]  a_exp_p0, b_exp_p0;
  logic [9:0]  a_frc_p0, b_frc_p0;
  logic [10:0] a_sig_p0, b_sig_p0;
  logic        a_zero_p0, b_zero_p0, a_inf_p0, b_inf_p0, a_nan_p0, b_nan_p0;

  assign a_sgn_p0     = opA[15];
  assign b_sgn_p0     = opB[15];
  assign a_exp_p0     = opA[14:10];
  assign b_exp_p0     = opB[14:10];
  assign a_frc_p0     = opA[9:0];
  assign b_frc_p0     = opB[9:0];
  assign a_sig_p0     = {1'b1, a_frc_p0};
  assign b_sig_p0     = {1'b1, b_frc_p0};
  assign a_zero_p0    = (a_exp_p0 == 5'd0);
  assign b_zero_p0    = (b_exp_p0 == 5'd0);
  assign a_inf_p0     = (a_exp_p0 == 5'd31) && (a_frc_p0 == 10'd0);
  assign b_inf_p0     = (b_exp_p0 == 5'd31) && (b_frc_p0 == 10'd0);
  assign a_nan_p0     = (a_exp_p0 == 5'd31) && (a_frc_p0 != 10'd0);
  assign b_nan_p0     = (b_exp_p0 == 5'd31) && (b_frc_p0 != 10'd0);
  assign b_sgn_eff_p0 = (op == OP_SUB) ? ~b_sgn_p0 : b_sgn_p0;

  logic               l_sgn_p0, s_sgn_p0;
  logic [4:0]         l_exp_p0, s_exp_p0, diff_p0;
  logic [10:0]        l_sig_p0, s_sig_p0;
  logic [30:0]        s_wide_p0;
  logic [13:0]        s_al_p0;
  logic [14:0]        sum_p0;
  logic [3:0]         lz_p0;
  logic [13:0]        add_sig_p0;
  logic signed [7:0]  add_exp_p0;
  logic [18:0]        add_rnd_p0;

  // Add/sub: order operands by magnitude, align the smaller one with sticky, add or subtract, renormalise.
  always_comb begin
    add_sig_p0 = 14'd0;
    add_exp_p0 = 8'sd0;
    if ({a_exp_p0, a_frc_p0} >= {b_exp_p0, b_frc_p0}) begin
      l_sgn_p0 = a_sgn_p0;     l_exp_p0 = a_exp_p0; l_sig_p0 = a_sig_p0;
      s_sgn_p0 = b_sgn_eff_p0; s_exp_p0 = b_exp_p0; s_sig_p0 = b_sig_p0;
    end else begin
      l_sgn_p0 = b_sgn_eff_p0; l_exp_p0 = b_exp_p0; l_sig_p0 = b_sig_p0;
      s_sgn_p0 = a_sgn_p0;     s_exp_p0 = a_exp_p0; s_sig_p0 = a_sig_p0;
    end
    diff_p0   = l_exp_p0 - s_exp_p0;
    s_wide_p0 = {s_sig_p0, 20'b0} >> diff_p0;
    s_al_p0   = {s_wide_p0[30:18], |s_wide_p0[17:0]};
    if (l_sgn_p0 ^ s_sgn_p0)
      sum_p0 = {1'b0, l_sig_p0, 3'b000} - {1'b0, s_al_p0};
    else
      sum_p0 = {1'b0, l_sig_p0, 3'b000} + {1'b0, s_al_p0};
    lz_p0 = lzc14(sum_p0[13:0]);
    if (sum_p0[14]) begin
      add_sig_p0 = {sum_p0[14:2], sum_p0[1] | sum_p0[0]};
      add_exp_p0 = $signed({3'b000, l_exp_p0}) + 8'sd1;
    end else begin
      add_sig_p0 = sum_p0[13:0] << lz_p0;
      add_exp_p0 = $signed({3'b000, l_exp_p0}) - $signed({4'b0000, lz_p0});
    end
    add_rnd_p0 = round_pack(l_sgn_p0, add_exp_p0, add_sig_p0);
  end

  logic [21:0]        prod_p0;
  logic [13:0]        mul_sig_p0;
  logic signed [7:0]  mul_exp_p0;
  logic               mul_sgn_p0;
  logic [18:0]        mul_rnd_p0;

  // Multiply: 11x11 significand product with a single-position normalisation.
  always_comb begin
    prod_p0    = a_sig_p0 * b_sig_p0;
    mul_sgn_p0 = a_sgn_p0 ^ b_sgn_p0;
    mul_exp_p0 = $signed({3'b000, a_exp_p0}) + $signed({3'b000, b_exp_p0}) - 8'sd15
                 + (prod_p0[21] ? 8'sd1 : 8'sd0);
    mul_sig_p0 = prod_p0[21] ? {prod_p0[21:9], |prod_p0[8:0]}
                             : {prod_p0[20:8], |prod_p0[7:0]};
    mul_rnd_p0 = round_pack(mul_sgn_p0, mul_exp_p0, mul_sig_p0);
  end

  logic [14:0] a_mag_p0, b_mag_p0;
  logic        a_win_p0;
  logic [15:0] res_p0;
  logic        ovf_p0, unf_p0, inx_p0;

  // Result select: specials first, then per-op arithmetic path; subnormals compare as zero in max.
  always_comb begin
    res_p0   = 16'h0000;
    ovf_p0   = 1'b0;
    unf_p0   = 1'b0;
    inx_p0   = 1'b0;
    a_mag_p0 = a_zero_p0 ? 15'd0 : opA[14:0];
    b_mag_p0 = b_zero_p0 ? 15'd0 : opB[14:0];
    if (a_sgn_p0 != b_sgn_p0) a_win_p0 = ~a_sgn_p0;
    else if (!a_sgn_p0)       a_win_p0 = (a_mag_p0 >= b_mag_p0);
    else                      a_win_p0 = (a_mag_p0 <= b_mag_p0);
    if (a_nan_p0 || b_nan_p0) begin
      res_p0 = QNAN;
    end else begin
      case (op)
        OP_ADD, OP_SUB: begin
          if (a_inf_p0 || b_inf_p0) begin
            if (a_inf_p0 && b_inf_p0 && (a_sgn_p0 != b_sgn_eff_p0)) res_p0 = QNAN;
            else if (a_inf_p0) res_p0 = {a_sgn_p0, INF};
            else               res_p0 = {b_sgn_eff_p0, INF};
          end else if (a_zero_p0 && b_zero_p0) begin
            res_p0 = {a_sgn_p0 & b_sgn_eff_p0, 15'h0000};
          end else if (a_zero_p0) begin
            res_p0 = {b_sgn_eff_p0, opB[14:0]};
          end else if (b_zero_p0) begin
            res_p0 = opA;
          end else if (sum_p0 == 15'd0) begin
            res_p0 = 16'h0000;
          end else begin
            {res_p0, ovf_p0, unf_p0, inx_p0} = add_rnd_p0;
          end
        end
        OP_MUL: begin
          if ((a_inf_p0 && b_zero_p0) || (b_inf_p0 && a_zero_p0))
            res_p0 = QNAN;
          else if (a_inf_p0 || b_inf_p0)
            res_p0 = {mul_sgn_p0, INF};
          else if (a_zero_p0 || b_zero_p0)
            res_p0 = {mul_sgn_p0, 15'h0000};
          else
            {res_p0, ovf_p0, unf_p0, inx_p0} = mul_rnd_p0;
        end
        OP_MAX: begin
          res_p0 = a_win_p0 ? {a_sgn_p0, a_mag_p0} : {b_sgn_p0, b_mag_p0};
        end
        default: res_p0 = 16'h0000;
      endcase
    end
  end

  // ---- stage p1: output registers ----
  // Capture the result and flags each cycle; async reset clears them immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= 16'h0000;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      result    <= res_p0;
      overflow  <= ovf_p0;
      underflow <= unf_p0;
      inexact   <= inx_p0;
    end
  end

endmodule

// File: tb/tb_fp16_fpu.sv
// Testbench for fp16_fpu.
// Each vector is {opA, opB, op, expected result, expected flags {ovf, unf, inx}}.
// A vector goes into a scoreboard when it is driven and is checked one cycle later.
module tb_fp16_fpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] opA, opB;
  logic [1:0]  op;
  logic [15:0] result;
  logic        overflow, underflow, inexact;

  int checks = 0;
  int failures = 0;
  logic [52:0] sb[$];
  logic [52:0] e;

  fp16_fpu dut (
    .clk(clk), .reset(reset), .opA(opA), .opB(opB), .op(op),
    .result(result), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [52:0] v);
    opA = v[52:37];
    opB = v[36:21];
    op  = v[20:19];
    sb.push_back(v);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opA = 16'h7BFF; opB = 16'h4000; op = 2'b10;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({result, overflow, underflow, inexact} !== 19'h0) begin
      failures++;
      $display("FAIL reset_state: got %h flags %b, want 0000 flags 000", result, {overflow, underflow, inexact});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_addsub();
    logic [52:0] tbl [11] = '{
      {16'h3C00, 16'h3C00, 2'b00, 16'h4000, 3'b000},
      {16'h3C00, 16'h3C00, 2'b01, 16'h0000, 3'b000},
      {16'h8000, 16'h8000, 2'b00, 16'h8000, 3'b000},
      {16'h3C00, 16'h1000, 2'b00, 16'h3C00, 3'b001},
      {16'h3C00, 16'h1001, 2'b00, 16'h3C01, 3'b001},
      {16'h3C01, 16'h1000, 2'b00, 16'h3C02, 3'b001},
      {16'h4000, 16'h3C00, 2'b01, 16'h3C00, 3'b000},
      {16'hC000, 16'h3C00, 2'b00, 16'hBC00, 3'b000},
      {16'h7BFF, 16'h7BFF, 2'b00, 16'h7C00, 3'b101},
      {16'h0400, 16'h0401, 2'b01, 16'h8000, 3'b011},
      {16'h0001, 16'h3C00, 2'b00, 16'h3C00, 3'b000}};
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL addsub: scoreboard empty");
        end else begin
          e = sb.pop_front(); checks++;
          if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
            failures++;
            $display("FAIL addsub %h op%0d %h: got %h flags %b, want %h flags %b", e[52:37], e[20:19], e[36:21], result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
          end
        end
      end
      if (i < 11) issue(tbl[i]);
    end
  endtask

  task automatic test_mul();
    logic [52:0] tbl [6] = '{
      {16'h4000, 16'h4200, 2'b10, 16'h4600, 3'b000},
      {16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 3'b101},
      {16'h0400, 16'h3800, 2'b10, 16'h0000, 3'b011},
      {16'hC000, 16'h3C00, 2'b10, 16'hC000, 3'b000},
      {16'h3C01, 16'h3C01, 2'b10, 16'h3C02, 3'b001},
      {16'h8000, 16'h4000, 2'b10, 16'h8000, 3'b000}};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL mul: scoreboard empty");
        end else begin
          e = sb.pop_front(); checks++;
          if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
            failures++;
            $display("FAIL mul %h * %h: got %h flags %b, want %h flags %b", e[52:37], e[36:21], result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
          end
        end
      end
      if (i < 6) issue(tbl[i]);
    end
  endtask

  task automatic test_specials();
    logic [52:0] tbl [9] = '{
      {16'h7C00, 16'h7C00, 2'b01, 16'h7E00, 3'b000},
      {16'h0000, 16'h7C00, 2'b10, 16'h7E00, 3'b000},
      {16'h7E01, 16'h3C00, 2'b00, 16'h7E00, 3'b000},
      {16'h7C00, 16'h3C00, 2'b00, 16'h7C00, 3'b000},
      {16'h3C00, 16'h7C00, 2'b01, 16'hFC00, 3'b000},
      {16'hFC00, 16'h4000, 2'b10, 16'hFC00, 3'b000},
      {16'h7C00, 16'h7C00, 2'b10, 16'h7C00, 3'b000},
      {16'h7C00, 16'h7C00, 2'b00, 16'h7C00, 3'b000},
      {16'h3C00, 16'h7E00, 2'b11, 16'h7E00, 3'b000}};
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL specials: scoreboard empty");
        end else begin
          e = sb.pop_front(); checks++;
          if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
            failures++;
            $display("FAIL specials %h op%0d %h: got %h flags %b, want %h flags %b", e[52:37], e[20:19], e[36:21], result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
          end
        end
      end
      if (i < 9) issue(tbl[i]);
    end
  endtask

  task automatic test_max();
    logic [52:0] tbl [6] = '{
      {16'hC000, 16'h3C00, 2'b11, 16'h3C00, 3'b000},
      {16'h8000, 16'h0000, 2'b11, 16'h0000, 3'b000},
      {16'h0000, 16'h8000, 2'b11, 16'h0000, 3'b000},
      {16'hC000, 16'hBC00, 2'b11, 16'hBC00, 3'b000},
      {16'h7C00, 16'h7BFF, 2'b11, 16'h7C00, 3'b000},
      {16'hFC00, 16'hC000, 2'b11, 16'hC000, 3'b000}};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL max: scoreboard empty");
        end else begin
          e = sb.pop_front(); checks++;
          if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
            failures++;
            $display("FAIL max(%h,%h): got %h flags %b, want %h flags %b", e[52:37], e[36:21], result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
          end
        end
      end
      if (i < 6) issue(tbl[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [52:0] tbl [8] = '{
      {16'h3C00, 16'h3C00, 2'b00, 16'h4000, 3'b000},
      {16'h4000, 16'h4200, 2'b10, 16'h4600, 3'b000},
      {16'hC000, 16'h3C00, 2'b11, 16'h3C00, 3'b000},
      {16'h4000, 16'h3C00, 2'b01, 16'h3C00, 3'b000},
      {16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 3'b101},
      {16'h3C00, 16'h1000, 2'b00, 16'h3C00, 3'b001},
      {16'h0400, 16'h3800, 2'b10, 16'h0000, 3'b011},
      {16'h7C00, 16'h7C00, 2'b01, 16'h7E00, 3'b000}};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL b2b: scoreboard empty");
        end else begin
          e = sb.pop_front(); checks++;
          if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
            failures++;
            $display("FAIL b2b[%0d] %h op%0d %h: got %h flags %b, want %h flags %b", i - 1, e[52:37], e[20:19], e[36:21], result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
          end
        end
      end
      if (i < 8) issue(tbl[i]);
    end
  endtask

  task automatic test_reset_midstream();
    logic [52:0] tbl [2] = '{
      {16'h3C00, 16'h1000, 2'b00, 16'h3C00, 3'b001},
      {16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 3'b101}};
    @(negedge clk);
    issue({16'h7BFF, 16'h4000, 2'b10, 16'h7C00, 3'b101});
    @(posedge clk); #2;
    reset = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({result, overflow, underflow, inexact} !== 19'h0) begin
      failures++;
      $display("FAIL reset_async: got %h flags %b, want 0000 flags 000", result, {overflow, underflow, inexact});
    end
    @(posedge clk); #1;
    checks++;
    if ({result, overflow, underflow, inexact} !== 19'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h flags %b, want 0000 flags 000", result, {overflow, underflow, inexact});
    end
    @(negedge clk);
    reset = 1'b1;
    issue(tbl[0]);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++; failures++; $display("FAIL reset_resume: scoreboard empty");
      end else begin
        e = sb.pop_front(); checks++;
        if ({result, overflow, underflow, inexact} !== {e[18:3], e[2:0]}) begin
          failures++;
          $display("FAIL reset_resume[%0d]: got %h flags %b, want %h flags %b", i - 1, result, {overflow, underflow, inexact}, e[18:3], e[2:0]);
        end
      end
      if (i < 2) issue(tbl[i]);
    end
  endtask

  initial begin
    reset = 1'b0;
    opA = 16'h0000; opB = 16'h0000; op = 2'b00;
    test_reset();
    test_addsub();
    test_mul();
    test_specials();
    test_max();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
